// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register slice:
//   - ALU operation class encodings driven by decode on ALUOp
//   - RV opcode constants used by decode when building the control bundle
//   - the seven-field control bundle carried from ID into EX
//   - the two per-cycle pipeline decisions (ADVANCE / BUBBLE)
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

  // ALU operation class (ALUOp)
  localparam logic [1:0] ALUOP_MEM    = 2'b00;  // load / store / addi
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // conditional branch compare
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // register-register ops

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Control bundle carried through the ID/EX register
  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  // Bundle value loaded on a bubble: no side effects in later stages
  localparam ctrl_t CTRL_NOP = '{
    branch:     1'b0,
    mem_read:   1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    reg_write:  1'b0,
    alu_op:     2'b00
  };

  // Per-cycle pipeline decision
  typedef enum logic {
    PIPE_ADVANCE = 1'b0,
    PIPE_BUBBLE  = 1'b1
  } pipe_state_e;

endpackage : id_ex_stage_pkg

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of the decode-side inputs and EX-side outputs of the ID/EX register.
//   master : decode / environment side (drives id_*, flush; sees ex_*, stall)
//   slave  : the id_ex_stage register itself
// Signals:
//   id_valid, Branch..RegWrite, ALUOp, id_pc, id_rs1_data, id_rs2_data, id_imm,
//   id_rs1, id_rs2, id_rd, id_funct, flush          -> into the stage
//   ex_valid, ex_<control>, ex_ALUOp, ex_<datapath>, id_stall, bubble_cnt
//                                                    <- out of the stage
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);

  // Decode side
  logic              id_valid;
  logic              Branch;
  logic              MemRead;
  logic              MemtoReg;
  logic              MemWrite;
  logic              ALUSrc;
  logic              RegWrite;
  logic [1:0]        ALUOp;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [3:0]        id_funct;
  logic              flush;

  // EX side
  logic              ex_valid;
  logic              ex_Branch;
  logic              ex_MemRead;
  logic              ex_MemtoReg;
  logic              ex_MemWrite;
  logic              ex_ALUSrc;
  logic              ex_RegWrite;
  logic [1:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_rs1_data;
  logic [DATA_W-1:0] ex_rs2_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [3:0]        ex_funct;
  logic              id_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           ALUOp, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_funct, flush,
    input  ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
           ex_ALUSrc, ex_RegWrite, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, id_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
           ALUOp, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_funct, flush,
    output ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
           ex_ALUSrc, ex_RegWrite, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, id_stall, bubble_cnt
  );

endinterface : id_ex_stage_if

// File: rtl/id_ex_stage_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard check: the instruction in EX is a valid
// load whose destination (non-zero) is a source of the valid instruction in ID.
// Ports:
//   id_valid_i    decode instruction valid
//   ex_valid_i    EX instruction valid
//   ex_mem_read_i EX instruction is a load
//   ex_rd_i       EX destination register
//   id_rs1_i      decode source register 1
//   id_rs2_i      decode source register 2
//   hazard_o      load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect (
  input  logic       id_valid_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  logic rd_nonzero_s;
  logic src_match_s;

  // x0 is hard-wired to zero, so a load into x0 never creates a dependency
  assign rd_nonzero_s = (ex_rd_i != 5'd0);
  assign src_match_s  = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
  assign hazard_o     = id_valid_i & ex_valid_i & ex_mem_read_i &
                        rd_nonzero_s & src_match_s;

endmodule : load_use_detect

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall generation and a saturating
// bubble counter. Each cycle either ADVANCEs the decode instruction into EX or
// inserts a BUBBLE (flush, load-use hazard, or no valid decode instruction).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears all EX outputs and counter)
//   bus    id_ex_stage_if.slave: decode inputs, EX outputs, id_stall
//          (combinational) and bubble_cnt
// Build option:
//   HAZARD_DETECT_EN  defined   -> load-use detection drives id_stall
//                     undefined -> no hazard detection, id_stall tied low
// -----------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              hazard_s;
  pipe_state_e       state_s;
  logic              count_s;
  ctrl_t             ctrl_id_s;

  logic              valid_d, valid_q;
  ctrl_t             ctrl_d,  ctrl_q;
  logic [CNT_W-1:0]  cnt_d,   cnt_q;

  logic [DATA_W-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [3:0]        funct_q;

  assign ctrl_id_s = '{
    branch:     bus.Branch,
    mem_read:   bus.MemRead,
    mem_to_reg: bus.MemtoReg,
    mem_write:  bus.MemWrite,
    alu_src:    bus.ALUSrc,
    reg_write:  bus.RegWrite,
    alu_op:     bus.ALUOp
  };

`ifdef HAZARD_DETECT_EN
  load_use_detect u_load_use_detect (
    .id_valid_i    (bus.id_valid),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .hazard_o      (hazard_s)
  );
`else
  assign hazard_s = 1'b0;
`endif

  // Flush wins over the hazard: the stalled instruction is being killed anyway
  assign bus.id_stall = hazard_s & ~bus.flush;

  // Only real instructions that get held or killed are counted as bubbles
  assign count_s = bus.id_valid & (hazard_s | bus.flush);

  // Choose ADVANCE/BUBBLE and form next control state and bubble count
  always_comb begin
    state_s = PIPE_BUBBLE;
    valid_d = 1'b0;
    ctrl_d  = CTRL_NOP;
    cnt_d   = cnt_q;

    if (bus.id_valid && !bus.flush && !hazard_s) begin
      state_s = PIPE_ADVANCE;
    end else begin
      state_s = PIPE_BUBBLE;
    end

    case (state_s)
      PIPE_ADVANCE: begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_id_s;
      end
      PIPE_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
      end
      default: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_NOP;
      end
    endcase

    if (count_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control, valid and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath fields load unconditionally; on a bubble they are don't-care
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= {DATA_W{1'b0}};
      rs1_data_q <= {DATA_W{1'b0}};
      rs2_data_q <= {DATA_W{1'b0}};
      imm_q      <= {DATA_W{1'b0}};
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      funct_q    <= 4'd0;
    end else begin
      pc_q       <= bus.id_pc;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
      rs1_q      <= bus.id_rs1;
      rs2_q      <= bus.id_rs2;
      rd_q       <= bus.id_rd;
      funct_q    <= bus.id_funct;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_Branch   = ctrl_q.branch;
  assign bus.ex_MemRead  = ctrl_q.mem_read;
  assign bus.ex_MemtoReg = ctrl_q.mem_to_reg;
  assign bus.ex_MemWrite = ctrl_q.mem_write;
  assign bus.ex_ALUSrc   = ctrl_q.alu_src;
  assign bus.ex_RegWrite = ctrl_q.reg_write;
  assign bus.ex_ALUOp    = ctrl_q.alu_op;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_rs1_data = rs1_data_q;
  assign bus.ex_rs2_data = rs2_data_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_funct    = funct_q;
  assign bus.bubble_cnt  = cnt_q;

endmodule : id_ex_stage

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 64, width of PC, register operands and immediate.
REQ-002 Parameter: CNT_W, 16, width of bubble counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  decode stage holds a valid instruction.
REQ-006 Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  input  1 each  decode control fields.
REQ-007 ALUOp  input  2  decode ALU operation class.
REQ-008 id_pc, id_rs1_data, id_rs2_data, id_imm  input  DATA_W each  decode datapath values.
REQ-009 id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-010 id_funct  input  4  {instr[30], instr[14:12]} for ALU control.
REQ-011 flush  input  1  branch resolved taken downstream; kill decode instruction.
REQ-012 ex_valid, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  output  1 each  registered EX-stage copies.
REQ-013 ex_ALUOp  output  2; ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  DATA_W; ex_rs1, ex_rs2, ex_rd  output  5; ex_funct  output  4  registered EX-stage copies.
REQ-014 id_stall  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-015 bubble_cnt  output  CNT_W  count of bubbles inserted.

Function
REQ-016 Latency: one cycle; values captured at edge N appear on ex_* after edge N.
REQ-017 Load-use hazard = id_valid & ex_valid & ex_MemRead & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-018 id_stall = hazard & ~flush.
REQ-019 Bubble: on edge, if flush or hazard or ~id_valid, ex_valid and all ex_ control outputs load 0; datapath ex_ fields may load any value.
REQ-020 Otherwise (normal advance), all ex_ outputs load their id_ inputs and ex_valid loads 1.
REQ-021 Flush has priority over hazard: flush with hazard -> bubble, id_stall=0, stalled instruction discarded.
REQ-022 A stalled instruction advances on the cycle after the bubble (hazard clears because ex_valid=0).
REQ-023 bubble_cnt increments by 1 on each edge where hazard or flush inserts a bubble while id_valid=1; saturates at all-ones.
REQ-024 ~id_valid bubbles do not increment bubble_cnt.
REQ-025 No state machine beyond the register; pipeline states are ADVANCE and BUBBLE, chosen per cycle by REQ-019/020.

Reset
REQ-026 rst_n low asynchronously clears every ex_ output, ex_valid and bubble_cnt to 0.
REQ-027 Reset mid-stall: stall released immediately (id_stall=0 since ex_valid=0); first post-reset edge behaves per REQ-019/020.

Configuration
REQ-028 Macro HAZARD_DETECT_EN defined: hazard detection per REQ-017, id_stall driven.
REQ-029 HAZARD_DETECT_EN undefined: hazard forced 0, id_stall tied 0, bubbles only from flush or ~id_valid; software must schedule load-use gaps.

Structure
REQ-030 Shared package holds the ALUOp encodings (00 load/store/addi, 01 branch, 10 R-type), opcode constants and a control-bundle struct typedef (seven control fields).
REQ-031 Hazard comparison is one sub-module, load_use_detect, purely combinational; register and counter stay in id_ex_stage.

Verification
REQ-032 R-type add, id_rd=5, RegWrite=1, ALUOp=10 -> next cycle ex_valid=1, ex_rd=5, ex_ALUOp=10, id_stall=0.
REQ-033 ld x3 then add x4,x3,x1 back-to-back -> id_stall=1 one cycle, bubble (ex_valid=0), add appears next cycle, bubble_cnt=1.
REQ-034 ld x0 then add x4,x0,x1 -> no stall, bubble_cnt=0.
REQ-035 flush=1 coincident with load-use hazard -> id_stall=0, ex_valid=0 next cycle, bubble_cnt+1.
REQ-036 Preload bubble_cnt to all-ones via repeated hazards -> further hazard keeps value all-ones.
REQ-037 rst_n low during stall -> all ex_ outputs 0 immediately, id_stall=0, bubble_cnt=0.
